simdev_arb: RTL and testbench
=============================

# simdev_arb

Round-robin arbiter and sequencer that shares one SimDev 8-bit adder between `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and issues a single-cycle `dev_ena` pulse. It waits for the device's `ok` pulse, returns the sum tagged with the requester index, and recovers by timeout if `ok` never arrives. It sits between the requester-side bus logic and a single SimDev instance, and is the only driver of that instance's `ena`, `inA` and `inB`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: maximum WAIT cycles before an error response; must be ≥ 10.
- `IDW`, `$clog2(NREQ)`: requester index width (derived).

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high; also drives the SimDev `rst`
- `req_valid`  in  NREQ  per-requester request valid
- `req_a`  in  NREQ*8  packed operand A; slice i belongs to requester i
- `req_b`  in  NREQ*8  packed operand B
- `req_ready`  out  NREQ  one-hot accept; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high
- `rsp_valid`  out  1  single-cycle response pulse
- `rsp_id`  out  IDW  index of the requester that owns the response
- `rsp_data`  out  8  sum, modulo 256
- `rsp_err`  out  1  timeout flag; qualified by `rsp_valid`
- `busy`  out  1  high in any state other than IDLE
- `dev_ena`  out  1  to SimDev `ena`
- `dev_a`, `dev_b`  out  8  to SimDev `inA`/`inB`
- `dev_out`  in  8  from SimDev `out`
- `dev_ok`  in  1  from SimDev `ok`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant the first requester with `req_valid` set, scanning from `last+1` mod `NREQ`.
  - `req_ready` is combinational, one-hot on the grant, and zero when no request is pending.
  - On transfer: latch the operands, the id into `cur_id`, and `last` ← grant. Next state is ISSUE.
- **ISSUE**
  - `dev_ena` = 1 for exactly this cycle.
  - `dev_a`/`dev_b` = latched operands. They hold their values in all states and are 0 after reset.
  - Clear `wcnt`. Next state is WAIT.
- **WAIT**
  - `wcnt` increments each cycle.
  - If `dev_ok` = 1: capture `dev_out` into `rsp_data`, set `rsp_err` = 0, next state RESP.
  - Else if `wcnt` == `TIMEOUT`-1: set `rsp_data` = 0, `rsp_err` = 1, next state RESP.
  - If `dev_ok` and the timeout occur in the same cycle, `dev_ok` wins.
- **RESP**
  - `rsp_valid` = 1 for one cycle, `rsp_id` = `cur_id`. Next state is IDLE.
  - There is no response backpressure; requesters must sample the pulse.
- `dev_ok` is ignored outside WAIT.
- Requesters must hold `req_valid` and operands stable until `req_ready` is seen.
- Fairness: after requester i is granted, i has lowest priority at the next arbitration.
- Reset values:
  - State IDLE, `last` = `NREQ`-1, so requester 0 has highest priority.
  - `req_ready`, `rsp_valid`, `rsp_err`, `rsp_data`, `rsp_id`, `busy`, `dev_ena`, `dev_a`, `dev_b` are all 0.
- Reset asserted mid-operation:
  - Abort without producing a response.
  - No `rsp_valid` is emitted for the aborted request.
  - SimDev is reset by the same `rst`, so a stale `ok` cannot arrive.

## Timing
- Cycle 0: IDLE, transfer with requester i.
- Cycle 1: ISSUE, `dev_ena` high. SimDev samples it at the end of cycle 1.
- SimDev: `out` is valid from cycle 2, and `ok` is high for exactly one cycle, in cycle 10.
- Cycles 2–10: WAIT, with `wcnt` = 0..8. `ok` is captured at the end of cycle 10.
- Cycle 11: RESP, `rsp_valid` high.
- Cycle 12: IDLE; the earliest next accept.
- Latency is 11 cycles from accept to response. Sustained throughput is one operation per 12 cycles.
- Timeout response, with `TIMEOUT` = 15: WAIT runs for cycles 2–16, and `rsp_valid` with `rsp_err` appears in cycle 17.
- `req_ready` is never high while `busy` is high.

## Test plan
- **Single request:** requester 2 sends A=0x12, B=0x34 in cycle 0.
  - `dev_ena` pulses in cycle 1.
  - Cycle 11: `rsp_valid`=1, `rsp_id`=2, `rsp_data`=0x46, `rsp_err`=0.
- **Overflow:** A=0xF0, B=0x20 → `rsp_data`=0x10.
- **Round-robin:** all four requesters hold `req_valid` after reset.
  - Grant order is 0,1,2,3,0, with accepts in cycles 0, 12, 24, 36, 48.
  - Each `rsp_id` matches its grant, and `dev_ena` pulses exactly once per grant.
- **Timeout:** replace SimDev with a stub that never asserts `ok`.
  - Cycle 17: `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0.
  - FSM returns to IDLE and accepts again in cycle 18.
- **Reset mid-WAIT:** assert `rst` in cycle 5 for one cycle.
  - No `rsp_valid` is produced.
  - All outputs are 0 in cycle 6.
  - A new request to requester 1 then completes normally with 11-cycle latency.
- **Ok/timeout tie and stray ok:** use a stub with `TIMEOUT`=10 that returns `ok` in WAIT cycle 10.
  - Expect `rsp_err`=0 with the data.
  - A stray `dev_ok` pulse during IDLE must produce no response.

Source files
------------

// File: rtl/simdev_arb.sv
// Round-robin front end for one shared SimDev adder. It grants one requester,
// pulses ena, waits for ok or a timeout, and returns a single tagged response.
module simdev_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              dev_ena,
  output logic [7:0]        dev_a,
  output logic [7:0]        dev_b,
  input  logic [7:0]        dev_out,
  input  logic              dev_ok
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  cur_id;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic [CW-1:0]   wcnt;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NREQ);
  endfunction

  // Scan starts just after the last winner, so that winner is checked last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_vld && req_valid[rr_idx(last, k)]) begin
        grant_vld = 1'b1;
        grant_id  = rr_idx(last, k);
      end
    end
  end

  assign req_ready = (state == IDLE && grant_vld) ? (NREQ'(1) << grant_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      cur_id    <= '0;
      wcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      dev_ena   <= 1'b0;
      dev_a     <= '0;
      dev_b     <= '0;
    end else begin
      dev_ena   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            dev_a   <= req_a[{grant_id, 3'b000} +: 8];
            dev_b   <= req_b[{grant_id, 3'b000} +: 8];
            cur_id  <= grant_id;
            last    <= grant_id;
            dev_ena <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          // ok is checked first so a same-cycle ok beats the timeout.
          if (dev_ok) begin
            rsp_data  <= dev_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            state     <= RESP;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            state     <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simdev_arb.sv
// Bench for simdev_arb: two instances (TIMEOUT 15 and 10), each with a
// behavioural SimDev whose ok delay is programmable, plus a scoreboard.
module tb_simdev_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
    logic           err;
    logic [31:0]    cyc;
  } exp_t;

  logic [NREQ-1:0]   req_valid [2];
  logic [NREQ*8-1:0] req_a     [2];
  logic [NREQ*8-1:0] req_b     [2];
  logic [NREQ-1:0]   req_ready [2];
  logic              rsp_valid [2];
  logic [IDW-1:0]    rsp_id    [2];
  logic [7:0]        rsp_data  [2];
  logic              rsp_err   [2];
  logic              busy      [2];
  logic              dev_ena   [2];
  logic [7:0]        dev_a     [2];
  logic [7:0]        dev_b     [2];
  int                ok_delay  [2];
  logic              stray     [2];
  int                ena_cnt   [2];
  int                acc_cyc   [2];

  for (genvar u = 0; u < 2; u++) begin : g
    localparam int TO = (u == 0) ? 15 : 10;
    logic [7:0] m_out;
    logic       m_ok;
    int         m_cnt;
    exp_t       q[$];
    exp_t       e;
    exp_t       got;
    int         id;

    simdev_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[u]), .req_a(req_a[u]), .req_b(req_b[u]),
      .req_ready(req_ready[u]),
      .rsp_valid(rsp_valid[u]), .rsp_id(rsp_id[u]), .rsp_data(rsp_data[u]),
      .rsp_err(rsp_err[u]), .busy(busy[u]),
      .dev_ena(dev_ena[u]), .dev_a(dev_a[u]), .dev_b(dev_b[u]),
      .dev_out(m_out), .dev_ok(m_ok | stray[u])
    );

    // SimDev: ok rises ok_delay+1 cycles after the cycle ena is sampled; 0 = never.
    always @(posedge clk) begin
      if (rst) begin
        m_out <= '0;
        m_ok  <= 1'b0;
        m_cnt <= 0;
      end else begin
        m_ok <= 1'b0;
        if (dev_ena[u]) begin
          m_out <= 8'(dev_a[u] + dev_b[u]);
          m_cnt <= ok_delay[u];
        end else if (m_cnt != 0) begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) m_ok <= 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        if (|(req_valid[u] & req_ready[u])) begin
          id = 0;
          for (int i = 0; i < NREQ; i++) if (req_ready[u][i]) id = i;
          tests++;
          assert ($onehot(req_ready[u]) && busy[u] === 1'b0) else begin
            fails++;
            $error("FAIL grant_onehot u%0d ready=%b busy=%b required onehot,busy=0", u, req_ready[u], busy[u]);
          end
          e.id = IDW'(id);
          if (ok_delay[u] == 0 || ok_delay[u] + 2 > TO + 1) begin
            e.err  = 1'b1;
            e.data = 8'h00;
            e.cyc  = 32'(cyc + TO + 2);
          end else begin
            e.err  = 1'b0;
            e.data = 8'(req_a[u][id*8 +: 8] + req_b[u][id*8 +: 8]);
            e.cyc  = 32'(cyc + ok_delay[u] + 3);
          end
          q.push_back(e);
          acc_cyc[u] = cyc;
        end
        if (dev_ena[u]) begin
          ena_cnt[u]++;
          tests++;
          assert (cyc === acc_cyc[u] + 1) else begin
            fails++;
            $error("FAIL ena_cycle u%0d got cycle %0d required %0d", u, cyc, acc_cyc[u] + 1);
          end
        end
        if (rsp_valid[u]) begin
          tests++;
          assert (q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_rsp u%0d id=%0d data=%h err=%b required no response", u, rsp_id[u], rsp_data[u], rsp_err[u]);
          end
          if (q.size() != 0) begin
            e = q.pop_front();
            got = '{id: rsp_id[u], data: rsp_data[u], err: rsp_err[u], cyc: 32'(cyc)};
            tests++;
            assert (got === e) else begin
              fails++;
              $error("FAIL rsp u%0d got id=%0d data=%h err=%b cyc=%0d required id=%0d data=%h err=%b cyc=%0d",
                     u, got.id, got.data, got.err, got.cyc, e.id, e.data, e.err, e.cyc);
            end
          end
        end
      end
    end
  end

  function automatic int qsize(input int u);
    return (u == 0) ? g[0].q.size() : g[1].q.size();
  endfunction

  task automatic check_zero(input int u, input string tag);
    tests++;
    assert ({req_ready[u], rsp_valid[u], rsp_err[u], rsp_data[u], rsp_id[u], busy[u],
             dev_ena[u], dev_a[u], dev_b[u]} === '0) else begin
      fails++;
      $error("FAIL %s u%0d ready=%b rv=%b err=%b data=%h id=%0d busy=%b ena=%b a=%h b=%h required all 0",
             tag, u, req_ready[u], rsp_valid[u], rsp_err[u], rsp_data[u], rsp_id[u], busy[u],
             dev_ena[u], dev_a[u], dev_b[u]);
    end
  endtask

  task automatic wait_acc(input int u, output int c);
    bit seen = 0;
    c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (|(req_valid[u] & req_ready[u])) begin seen = 1; c = cyc; break; end
    end
    tests++;
    assert (seen) else begin
      fails++;
      $error("FAIL accept_timeout u%0d got no accept required accept", u);
    end
  endtask

  task automatic wait_drain(input int u);
    for (int n = 0; n < 60 && qsize(u) != 0; n++) @(negedge clk);
    tests++;
    assert (qsize(u) == 0) else begin
      fails++;
      $error("FAIL drain u%0d got %0d pending required 0", u, qsize(u));
    end
  endtask

  task automatic send(input int u, input int id, input logic [7:0] a, input logic [7:0] b);
    int c;
    req_a[u][id*8 +: 8] = a;
    req_b[u][id*8 +: 8] = b;
    req_valid[u][id] = 1'b1;
    wait_acc(u, c);
    @(posedge clk); #1;
    req_valid[u][id] = 1'b0;
  endtask

  task automatic quiet(input int u, input int n, input string tag);
    bit bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rsp_valid[u] !== 1'b0) bad = 1;
    end
    tests++;
    assert (bad == 0) else begin
      fails++;
      $error("FAIL %s u%0d got rsp_valid pulse required none", tag, u);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = '0; req_a[u] = '0; req_b[u] = '0;
      stray[u] = 1'b0; ena_cnt[u] = 0; acc_cyc[u] = 0;
    end
    ok_delay[0] = 8;
    ok_delay[1] = 9;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0, "reset_state");
    check_zero(1, "reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin: all requesters held, grants must be 0,1,2,3,0 every 12 cycles.
    req_a[0] = {8'h40, 8'h30, 8'h20, 8'h10};
    req_b[0] = {8'h04, 8'h03, 8'h02, 8'h01};
    req_valid[0] = 4'hF;
    c0 = 0;
    for (int k = 0; k < 5; k++) begin
      logic [NREQ-1:0] want;
      want = NREQ'(1) << (k % NREQ);
      wait_acc(0, c);
      tests++;
      assert (req_ready[0] === want) else begin
        fails++;
        $error("FAIL rr_grant k=%0d got %b required %b", k, req_ready[0], want);
      end
      if (k == 0) c0 = c;
      else begin
        tests++;
        assert (c === c0 + 12 * k) else begin
          fails++;
          $error("FAIL rr_cycle k=%0d got %0d required %0d", k, c - c0, 12 * k);
        end
      end
      @(posedge clk); #1;
    end
    req_valid[0] = '0;
    wait_drain(0);
    tests++;
    assert (ena_cnt[0] === 5) else begin
      fails++;
      $error("FAIL rr_ena_count got %0d required 5", ena_cnt[0]);
    end

    send(0, 2, 8'h12, 8'h34);
    wait_drain(0);
    send(0, 1, 8'hF0, 8'h20);
    wait_drain(0);

    // Timeout: device never answers; the held request is re-accepted 18 cycles later.
    ok_delay[0] = 0;
    req_a[0][3*8 +: 8] = 8'h55;
    req_b[0][3*8 +: 8] = 8'h11;
    req_valid[0][3] = 1'b1;
    wait_acc(0, c0);
    @(posedge clk); #1;
    wait_acc(0, c);
    tests++;
    assert (c === c0 + 18) else begin
      fails++;
      $error("FAIL timeout_reaccept got %0d required 18", c - c0);
    end
    @(posedge clk); #1;
    req_valid[0][3] = 1'b0;
    wait_drain(0);
    ok_delay[0] = 8;

    // Reset in the middle of WAIT aborts the request silently.
    req_a[0][7:0] = 8'h21;
    req_b[0][7:0] = 8'h43;
    req_valid[0][0] = 1'b1;
    wait_acc(0, c0);
    @(posedge clk); #1;
    req_valid[0][0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    g[0].q.delete();
    @(negedge clk);
    check_zero(0, "reset_abort");
    quiet(0, 15, "reset_no_rsp");
    send(0, 1, 8'h99, 8'h66);
    wait_drain(0);

    // ok arriving on the final WAIT cycle beats the timeout.
    send(1, 2, 8'h7F, 8'h01);
    wait_drain(1);
    @(posedge clk); #1;
    stray[1] = 1'b1;
    @(posedge clk); #1;
    stray[1] = 1'b0;
    quiet(1, 6, "stray_ok");
    tests++;
    assert (busy[1] === 1'b0) else begin
      fails++;
      $error("FAIL stray_busy got %b required 0", busy[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
